// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared op/state encodings and iteration count for multdiv32
package multdiv_pkg;
   localparam int ITERACOES = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      OCIOSO,
      CALCULA,
      AJUSTA,
      FIM
   } estado_t;
endpackage

// File: rtl/multdiv_passo.sv
// rtl/multdiv_passo.sv - one radix-2 step: shift-add multiply or restoring shift-subtract divide
module multdiv_passo (
   input  logic [63:0] acc,
   input  logic [31:0] operando,
   input  logic        divide,
   output logic [63:0] acc_prox
);
   logic [32:0] soma;
   logic [32:0] dif;

   // Divide keeps {remainder, dividend/quotient}; the shifted partial remainder needs 33 bits.
   always_comb begin
      soma     = {1'b0, acc[63:32]} + {1'b0, operando};
      dif      = acc[63:31] - {1'b0, operando};
      acc_prox = acc;
      if (divide) begin
         if (!dif[32]) acc_prox = {dif[31:0], acc[30:0], 1'b1};
         else          acc_prox = {acc[62:0], 1'b0};
      end else if (acc[0]) begin
         acc_prox = {soma, acc[31:1]};
      end else begin
         acc_prox = {1'b0, acc[63:1]};
      end
   end
endmodule

// File: rtl/multdiv32.sv
// rtl/multdiv32.sv - 32-bit iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
// Optional HI/LO direct-write port: define MULTDIV_MTHILO_EN.
module multdiv32
   import multdiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inicio,
   input  logic [1:0]  op,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
`ifdef MULTDIV_MTHILO_EN
   input  logic        escreveHI,
   input  logic        escreveLO,
   input  logic [31:0] dadoHILO,
`endif
   output logic        ocupado,
   output logic        pronto,
   output logic        divZero,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   estado_t     estado, prox;
   op_t         op_in, op_r;
   logic [63:0] acc, acc_prox, prod_aj;
   logic [31:0] divisor, abs_a, abs_b, quoc_aj, rest_aj;
   logic [5:0]  cnt;
   logic        neg_q, neg_r, dz_r, sinal, div_zero_in, eh_div;

   assign op_in       = op_t'(op);
   assign sinal       = (op_in == OP_MULT) || (op_in == OP_DIV);
   assign div_zero_in = op[1] && (SrcB == 32'd0);
   assign abs_a       = (sinal && SrcA[31]) ? (32'd0 - SrcA) : SrcA;
   assign abs_b       = (sinal && SrcB[31]) ? (32'd0 - SrcB) : SrcB;
   assign eh_div      = (op_r == OP_DIV) || (op_r == OP_DIVU);

   multdiv_passo u_passo (
      .acc      (acc),
      .operando (divisor),
      .divide   (eh_div),
      .acc_prox (acc_prox)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= OCIOSO;
      else     estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:  if (inicio) prox = div_zero_in ? FIM : CALCULA;
         CALCULA: if (cnt == 6'(ITERACOES - 1)) prox = AJUSTA;
         AJUSTA:  prox = FIM;
         FIM:     prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   // neg_q doubles as the product-sign flag for multiplies.
   always_comb begin
      prod_aj = neg_q ? (64'd0 - acc) : acc;
      quoc_aj = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
      rest_aj = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r    <= OP_MULT;
         acc     <= 64'd0;
         divisor <= 32'd0;
         cnt     <= 6'd0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz_r    <= 1'b0;
         HI      <= 32'd0;
         LO      <= 32'd0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (inicio) begin
                  op_r    <= op_in;
                  acc     <= {32'd0, abs_a};
                  divisor <= abs_b;
                  cnt     <= 6'd0;
                  dz_r    <= div_zero_in;
                  neg_q   <= sinal && (SrcA[31] ^ SrcB[31]);
                  neg_r   <= sinal && SrcA[31];
               end
`ifdef MULTDIV_MTHILO_EN
               else begin
                  if (escreveHI) HI <= dadoHILO;
                  if (escreveLO) LO <= dadoHILO;
               end
`endif
            end
            CALCULA: begin
               acc <= acc_prox;
               cnt <= cnt + 6'd1;
            end
            AJUSTA: begin
               if (eh_div) begin
                  HI <= rest_aj;
                  LO <= quoc_aj;
               end else begin
                  HI <= prod_aj[63:32];
                  LO <= prod_aj[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign ocupado = (estado != OCIOSO);
   assign pronto  = (estado == FIM);
   assign divZero = pronto && dz_r;
endmodule

// File: tb/tb_multdiv32.sv
// tb/tb_multdiv32.sv - self-checking bench for multdiv32: vector table, corner sequences, random vs model
module tb_multdiv32;
   logic        clk;
   logic        rst;
   logic        inicio;
   logic [1:0]  op;
   logic [31:0] SrcA, SrcB;
   logic        ocupado, pronto, divZero;
   logic [31:0] HI, LO;

   int n_cmp = 0;
   int n_bad = 0;

   multdiv32 dut (
      .clk     (clk),
      .rst     (rst),
      .inicio  (inicio),
      .op      (op),
      .SrcA    (SrcA),
      .SrcB    (SrcB),
      .ocupado (ocupado),
      .pronto  (pronto),
      .divZero (divZero),
      .HI      (HI),
      .LO      (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t tab[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] mh, inout logic [31:0] ml, output logic dz);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      case (o)
         2'b00: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
         2'b01: begin p = {32'd0, a} * {32'd0, b}; mh = p[63:32]; ml = p[31:0]; end
         2'b10: begin
            if (b == 32'd0) dz = 1'b1;
            else begin
               q = sa / sb;
               r = sa % sb;
               p = q; ml = p[31:0];
               p = r; mh = p[31:0];
            end
         end
         default: begin
            if (b == 32'd0) dz = 1'b1;
            else begin ml = a / b; mh = a % b; end
         end
      endcase
   endfunction

   // Operands and op are scrambled right after the start edge; the result must not care.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic dz, output int lat);
      @(negedge clk);
      inicio = 1'b1; op = o; SrcA = a; SrcB = b;
      @(posedge clk); #1;
      inicio = 1'b0; op = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
      lat = 0; h = 32'd0; l = 32'd0; dz = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (pronto) begin
            lat = i; h = HI; l = LO; dz = divZero;
            break;
         end
      end
      @(negedge clk);
      chk("pronto_single_cycle", {62'd0, pronto, ocupado}, 64'd0);
   endtask

   logic [31:0] mh, ml, h, l;
   logic        mdz, dz;
   int          lat, npr;
   logic        fim_ini;

   initial begin
      tab[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
      tab[1] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      tab[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      tab[3] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      tab[4] = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000001, 32'h00000003, 1'b1};
      tab[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      tab[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      tab[7] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      tab[8] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

      rst = 1'b1; inicio = 1'b0; op = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
      #1;
      chk("reset_hi", {32'd0, HI}, 64'd0);
      chk("reset_lo", {32'd0, LO}, 64'd0);
      chk("reset_flags", {61'd0, ocupado, pronto, divZero}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_op(tab[i].op, tab[i].a, tab[i].b, h, l, dz, lat);
         chk($sformatf("vec%0d_hi", i), {32'd0, h}, {32'd0, tab[i].hi});
         chk($sformatf("vec%0d_lo", i), {32'd0, l}, {32'd0, tab[i].lo});
         chk($sformatf("vec%0d_divzero", i), {63'd0, dz}, {63'd0, tab[i].dz});
         chk($sformatf("vec%0d_latency", i), 64'(lat), tab[i].dz ? 64'd1 : 64'd34);
      end

      // Reset ten cycles into a multiply: outputs clear at once and no pronto follows.
      @(negedge clk);
      inicio = 1'b1; op = 2'b00; SrcA = 32'd123; SrcB = 32'd456;
      @(posedge clk); #1;
      inicio = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ocupado", {63'd0, ocupado}, 64'd0);
      chk("abort_hilo", {HI, LO}, 64'd0);
      chk("abort_pronto", {63'd0, pronto}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      npr = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pronto) npr++;
      end
      chk("abort_no_pronto", 64'(npr), 64'd0);

      // Start after reset, then a stray inicio mid-divide and another in the FIM cycle.
      @(negedge clk);
      inicio = 1'b1; op = 2'b10; SrcA = 32'hFFFFFF9C; SrcB = 32'd7;
      @(posedge clk); #1;
      inicio = 1'b0;
      repeat (5) @(negedge clk);
      inicio = 1'b1; op = 2'b01; SrcA = 32'd5; SrcB = 32'd5;
      @(negedge clk);
      inicio = 1'b0;
      npr = 0; fim_ini = 1'b0; h = 32'd0; l = 32'd0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (fim_ini) begin
            chk("fim_inicio_ignored", {63'd0, ocupado}, 64'd0);
            inicio = 1'b0;
            fim_ini = 1'b0;
         end
         if (pronto) begin
            npr++;
            h = HI; l = LO;
            inicio = 1'b1; op = 2'b01; SrcA = 32'd3; SrcB = 32'd3;
            fim_ini = 1'b1;
         end
      end
      inicio = 1'b0;
      chk("busy_inicio_one_pronto", 64'(npr), 64'd1);
      chk("busy_div_result", {h, l}, {32'hFFFFFFFE, 32'hFFFFFFF2});

      mh = HI; ml = LO;
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         model(ro, ra, rb, mh, ml, mdz);
         do_op(ro, ra, rb, h, l, dz, lat);
         chk($sformatf("rnd%0d_op%0d_hi", i, ro), {32'd0, h}, {32'd0, mh});
         chk($sformatf("rnd%0d_op%0d_lo", i, ro), {32'd0, l}, {32'd0, ml});
         chk($sformatf("rnd%0d_divzero", i), {63'd0, dz}, {63'd0, mdz});
         chk($sformatf("rnd%0d_latency", i), 64'(lat), mdz ? 64'd1 : 64'd34);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multdiv32.md
MULTDIV32 -- requirements
Module: multdiv32

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port inicio, input, 1, start request, sampled only in state OCIOSO.
REQ-004 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with inicio.
REQ-005 SHALL have ports SrcA and SrcB, input, 32 each, operands (same register-file sources as the ALU); sampled with inicio.
REQ-006 SHALL have port ocupado, output, 1, high whenever the state is not OCIOSO.
REQ-007 SHALL have port pronto, output, 1, one-cycle completion pulse, high only in state FIM.
REQ-008 SHALL have port divZero, output, 1, high during pronto when the finished DIV/DIVU had SrcB==0; otherwise 0.
REQ-009 SHALL have ports HI and LO, output, 32 each, registered results, held until the next completion or reset.

Function
REQ-010 SHALL implement FSM states OCIOSO, CALCULA, AJUSTA and FIM.
REQ-011 Edge E0 (OCIOSO, inicio=1) SHALL latch op and the operands, taking absolute values for MULT/DIV, and go to CALCULA.
REQ-012 CALCULA SHALL run exactly 32 radix-2 iterations on edges E1..E32: shift-add for multiply, restoring shift-subtract for divide; a 6-bit counter goes to AJUSTA on E32.
REQ-013 AJUSTA SHALL apply sign correction on E33: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign. It then writes HI/LO and goes to FIM.
REQ-014 Result mapping SHALL be: multiply, HI = product[63:32] and LO = product[31:0]; divide, LO = quotient and HI = remainder.
REQ-015 FIM SHALL return to OCIOSO on E34, so ocupado is high for 34 cycles and pronto is high in the cycle between E33 and E34, when HI/LO are already valid.
REQ-016 DIV/DIVU with SrcB==0 SHALL go from OCIOSO straight to FIM on E0, leave HI/LO unchanged and assert divZero with pronto.
REQ-017 DIV with 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000, with no trap and no flag.
REQ-018 inicio asserted while ocupado=1 SHALL be ignored and not queued; inicio in the FIM cycle is also ignored.
REQ-019 Operand changes after E0 SHALL NOT affect the result.

Reset
REQ-020 rst=1 SHALL immediately force state OCIOSO, HI=LO=0, ocupado=0, pronto=0, divZero=0 and clear the counter and internal registers, including mid-operation, with no pronto for the aborted operation.
REQ-021 After rst falls, the first rising edge with inicio=1 SHALL start a new operation normally.

Configuration
REQ-022 Macro MULTDIV_MTHILO_EN, when defined, SHALL add inputs escreveHI (1), escreveLO (1) and dadoHILO (32). In OCIOSO these write dadoHILO into HI and/or LO on the next edge. When ocupado=1 the writes are ignored. If inicio and a write coincide, inicio wins.
REQ-023 When MULTDIV_MTHILO_EN is undefined, those ports and their logic SHALL be absent and HI/LO SHALL change only by REQ-013/REQ-020.

Structure
REQ-024 A shared package multdiv_pkg SHALL hold the op encoding enum, the FSM state enum and the constant ITERACOES=32.
REQ-025 The single combinational iteration step (add/subtract-and-shift on the 64-bit accumulator) SHALL be the sub-module multdiv_passo; the FSM, counter and sign logic stay in multdiv32.

Verification
REQ-026 MULT 0xFFFFFFFF x 0x00000002 SHALL give HI=0xFFFFFFFF and LO=0xFFFFFFFE, with pronto exactly 34 cycles after E0 counting ocupado cycles.
REQ-027 MULTU 0xFFFFFFFF x 0x00000002 SHALL give HI=0x00000001 and LO=0xFFFFFFFE.
REQ-028 DIV 0xFFFFFFF9 (-7) / 0x00000002 SHALL give LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU 7/2 SHALL give LO=3 and HI=1.
REQ-029 DIVU 0x00000007 / 0 after a prior result SHALL give pronto and divZero=1 one cycle after E0, with HI/LO unchanged.
REQ-030 rst pulsed at cycle 10 of a MULT SHALL give ocupado=0 and HI=LO=0 immediately with no pronto. inicio pulsed at cycle 5 of a DIV SHALL be ignored, giving exactly one pronto.
